// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: on a rising halt, streams the cycle count followed by
// R0..R31 over a valid/ready port, borrowing the rs read port while busy.
module regfile_dump_reader #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic [4:0]  cpu_rs_num,
  output logic [4:0]  rf_num,
  input  logic [31:0] rf_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        dump_busy,
  output logic        dump_done
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    REGS,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             halted_q, halted_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      dump_data_q, dump_data_d;
  logic             dump_valid_q, dump_valid_d;
  logic             dump_last_q, dump_last_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      halted_q     <= 1'b0;
      idx_q        <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      halted_q     <= halted_d;
      idx_q        <= idx_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q  <= dump_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q + CNT_W'(1);
    halted_d     = halted;
    idx_d        = idx_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = dump_valid_q;
    dump_last_d  = dump_last_q;
    accept       = dump_valid_q && dump_ready;

    unique case (state_q)
      IDLE: begin
        if (halted && !halted_q) begin
          dump_data_d  = 32'(cyc_q);
          dump_valid_d = 1'b1;
          idx_d        = '0;
          state_d      = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          dump_data_d = rf_data;
          idx_d       = 6'd1;
          state_d     = REGS;
        end
      end
      REGS: begin
        // idx points one past the register currently on dump_data; 32 means R31 is out
        if (accept) begin
          if (idx_q == 6'd32) begin
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
            state_d      = DONE;
          end else begin
            dump_data_d = rf_data;
            idx_d       = idx_q + 6'd1;
            dump_last_d = (idx_q == 6'd31);
          end
        end
      end
      DONE: begin
        if (!halted) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_busy  = (state_q == HDR) || (state_q == REGS);
  assign dump_done  = (state_q == DONE);
  assign rf_num     = dump_busy ? idx_q[4:0] : cpu_rs_num;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file (Rk = 0x1000+k, R0 = 0).
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic [4:0]  cpu_rs_num;
  logic [4:0]  rf_num;
  logic [31:0] rf_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        dump_busy;
  logic        dump_done;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [31:0] tb_cyc = '0;
  logic [31:0] cap_d [0:32];
  logic        cap_l [0:32];
  int unsigned n_got;
  int unsigned stall_bad;
  int unsigned col_cycles;

  regfile_dump_reader #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .halted     (halted),
    .cpu_rs_num (cpu_rs_num),
    .rf_num     (rf_num),
    .rf_data    (rf_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  assign rf_data = (rf_num == 5'd0) ? 32'h0 : (32'h1000 + {27'd0, rf_num});

  always @(posedge clk) tb_cyc <= rst_b ? tb_cyc + 32'd1 : 32'd0;

  function automatic logic [31:0] exp_beat(input int unsigned i, input logic [31:0] hdr);
    if (i == 0) return hdr;
    if (i == 1) return 32'h0;
    return 32'h1000 + 32'(i - 1);
  endfunction

  // Gathers accepted beats; records stalled-beat instability and cycles spent.
  task automatic collect(input int unsigned n_target, input bit bp);
    bit          stalled = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    n_got = 0;
    stall_bad = 0;
    col_cycles = 0;
    while (n_got < n_target && col_cycles < 600) begin
      @(negedge clk);
      dump_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      if (dump_valid) begin
        if (stalled && (dump_data !== pd || dump_last !== pl)) stall_bad++;
        if (dump_ready) begin
          cap_d[n_got] = dump_data;
          cap_l[n_got] = dump_last;
          n_got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = dump_data;
          pl = dump_last;
        end
      end else if (stalled) begin
        stall_bad++;
        stalled = 1'b0;
      end
      col_cycles++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; halted = 1'b0; dump_ready = 1'b0; cpu_rs_num = 5'h13;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dump_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", dump_valid); end
    checks++; if (dump_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", dump_last); end
    checks++; if (dump_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", dump_busy); end
    checks++; if (dump_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", dump_done); end
    checks++; if (dump_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", dump_data); end
    checks++; if (rf_num !== 5'h13) begin failures++; $display("FAIL reset_rf_num: got %h expected 13", rf_num); end
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] hdr;
    int          extra_valid = 0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    halted = 1'b1;
    hdr = tb_cyc;
    @(posedge clk);
    #1;
    checks++; if (dump_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid: got %b expected 1", dump_valid); end
    checks++; if (dump_busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", dump_busy); end
    checks++; if (rf_num !== 5'd0) begin failures++; $display("FAIL basic_rf_num_idx: got %h expected 0", rf_num); end
    checks++; if (dump_data !== hdr) begin failures++; $display("FAIL basic_header_early: got %h expected %h", dump_data, hdr); end
    collect(33, 1'b0);
    checks++; if (n_got !== 33) begin failures++; $display("FAIL basic_count: got %0d expected 33", n_got); end
    checks++; if (col_cycles !== 33) begin failures++; $display("FAIL basic_throughput: got %0d cycles expected 33", col_cycles); end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (cap_d[i] !== exp_beat(i, hdr)) begin failures++; $display("FAIL basic_beat%0d: got %h expected %h", i, cap_d[i], exp_beat(i, hdr)); end
      checks++;
      if (cap_l[i] !== 1'(i == 32)) begin failures++; $display("FAIL basic_last%0d: got %b expected %b", i, cap_l[i], (i == 32)); end
    end
    checks++; if (dump_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b expected 1", dump_done); end
    checks++; if (rf_num !== 5'h13) begin failures++; $display("FAIL basic_rf_num_back: got %h expected 13", rf_num); end
    repeat (10) begin
      @(negedge clk);
      if (dump_valid !== 1'b0) extra_valid++;
    end
    checks++; if (extra_valid !== 0) begin failures++; $display("FAIL basic_no_second_dump: got %0d valid cycles expected 0", extra_valid); end
    checks++; if (dump_done !== 1'b1) begin failures++; $display("FAIL basic_done_hold: got %b expected 1", dump_done); end
    halted = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (dump_done !== 1'b0) begin failures++; $display("FAIL basic_done_fall: got %b expected 0", dump_done); end
  endtask

  task automatic test_backpressure();
    logic [31:0] hdr;
    @(negedge clk);
    halted = 1'b1;
    hdr = tb_cyc;
    collect(33, 1'b1);
    checks++; if (n_got !== 33) begin failures++; $display("FAIL bp_count: got %0d expected 33", n_got); end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_bad); end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (cap_d[i] !== exp_beat(i, hdr)) begin failures++; $display("FAIL bp_beat%0d: got %h expected %h", i, cap_d[i], exp_beat(i, hdr)); end
      checks++;
      if (cap_l[i] !== 1'(i == 32)) begin failures++; $display("FAIL bp_last%0d: got %b expected %b", i, cap_l[i], (i == 32)); end
    end
    checks++; if (dump_done !== 1'b1) begin failures++; $display("FAIL bp_done: got %b expected 1", dump_done); end
    halted = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rearm();
    logic [31:0] hdr;
    @(negedge clk);
    halted = 1'b1;
    collect(33, 1'b0);
    halted = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    halted = 1'b1;
    hdr = tb_cyc;
    collect(33, 1'b0);
    checks++; if (n_got !== 33) begin failures++; $display("FAIL rearm_count: got %0d expected 33", n_got); end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (cap_d[i] !== exp_beat(i, hdr)) begin failures++; $display("FAIL rearm_beat%0d: got %h expected %h", i, cap_d[i], exp_beat(i, hdr)); end
      checks++;
      if (cap_l[i] !== 1'(i == 32)) begin failures++; $display("FAIL rearm_last%0d: got %b expected %b", i, cap_l[i], (i == 32)); end
    end
    halted = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_glitch();
    logic [31:0] hdr;
    @(negedge clk);
    halted = 1'b1;
    hdr = tb_cyc;
    @(posedge clk);
    #1;
    halted = 1'b0;
    collect(33, 1'b0);
    checks++; if (n_got !== 33) begin failures++; $display("FAIL glitch_count: got %0d expected 33", n_got); end
    checks++; if (cap_d[0] !== hdr) begin failures++; $display("FAIL glitch_header: got %h expected %h", cap_d[0], hdr); end
    checks++; if (cap_d[32] !== 32'h101F) begin failures++; $display("FAIL glitch_r31: got %h expected 0000101f", cap_d[32]); end
    checks++; if (cap_l[32] !== 1'b1) begin failures++; $display("FAIL glitch_last: got %b expected 1", cap_l[32]); end
    checks++; if (dump_done !== 1'b1) begin failures++; $display("FAIL glitch_done: got %b expected 1", dump_done); end
    @(posedge clk);
    #1;
    checks++; if (dump_done !== 1'b0) begin failures++; $display("FAIL glitch_idle_done: got %b expected 0", dump_done); end
    checks++; if (dump_busy !== 1'b0) begin failures++; $display("FAIL glitch_idle_busy: got %b expected 0", dump_busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hdr;
    @(negedge clk);
    halted = 1'b1;
    collect(11, 1'b0);
    rst_b = 1'b0;
    halted = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (dump_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", dump_valid); end
    checks++; if (dump_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", dump_busy); end
    checks++; if (dump_done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", dump_done); end
    checks++; if (rf_num !== 5'h13) begin failures++; $display("FAIL rstmid_rf_num: got %h expected 13", rf_num); end
    checks++; if (dut.cyc_q !== 32'h0) begin failures++; $display("FAIL rstmid_cyc: got %h expected 0", dut.cyc_q); end
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    halted = 1'b1;
    hdr = tb_cyc;
    collect(33, 1'b0);
    checks++; if (n_got !== 33) begin failures++; $display("FAIL rstmid_count: got %0d expected 33", n_got); end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (cap_d[i] !== exp_beat(i, hdr)) begin failures++; $display("FAIL rstmid_beat%0d: got %h expected %h", i, cap_d[i], exp_beat(i, hdr)); end
    end
    halted = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_q;
    repeat (3) @(posedge clk);
    @(negedge clk);
    halted = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (dump_data !== 32'h0000_0001) begin failures++; $display("FAIL wrap_header: got %h expected 00000001", dump_data); end
    collect(33, 1'b0);
    checks++; if (cap_d[0] !== 32'h0000_0001) begin failures++; $display("FAIL wrap_header_beat: got %h expected 00000001", cap_d[0]); end
    halted = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_rearm();
    test_glitch();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Hardware read-out engine for the processor register file. When the core asserts `halted`, the block takes over one register-file read port and reads R0..R31 in order. It streams a 33-beat dump over a valid/ready interface: one header beat carrying the cycle count, then 32 register values. This lets a host or trace sink capture final architectural state in hardware. The simulation-only file dump performs the equivalent job in software.

## Interface
- `CNT_W`, 32: width of the free-running cycle counter and of the header word (fixed at 32 in this version).
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_b`  in  1  synchronous active-low reset, sampled on posedge `clk`.
- `halted`  in  1  core halt indication; a rising edge starts a dump.
- `cpu_rs_num`  in  5  core's rs read address, passed through when not dumping.
- `rf_num`  out  5  address driven to the register-file rs read port.
- `rf_data`  in  32  combinational read data returned for `rf_num`; R0 reads 0.
- `dump_valid`  out  1  beat present on `dump_data`.
- `dump_ready`  in  1  sink accepts the beat when `dump_valid && dump_ready` at posedge.
- `dump_data`  out  32  header (cycle count) or register value.
- `dump_last`  out  1  marks the final beat (R31).
- `dump_busy`  out  1  high in states HDR and REGS.
- `dump_done`  out  1  high in state DONE.

## Operation
- Cycle counter `cyc`, 32 bits: cleared by reset, increments every cycle, wraps 0xFFFFFFFF -> 0, never stops.
- `halted_q`: registered copy of `halted`. Trigger = `halted && !halted_q`.
- Index `idx`, 6 bits: address of the next register to load. `rf_num` = `dump_busy ? idx[4:0] : cpu_rs_num`.
- FSM states: IDLE, HDR, REGS, DONE.
- IDLE:
  - On trigger: `dump_data <= cyc` (pre-increment value), `dump_valid <= 1`, `idx <= 0`, go to HDR.
  - Trigger is ignored in any state other than IDLE.
- HDR:
  - On accept: `dump_data <= rf_data` (R0), `idx <= 1`, go to REGS.
  - `dump_last` stays 0.
- REGS:
  - On accept with `idx == 32`: this is the R31 beat. Set `dump_valid <= 0`, `dump_last <= 0`, go to DONE.
  - On accept otherwise: `dump_data <= rf_data` (register `idx`), `idx <= idx + 1`, `dump_last <= (idx == 31)`.
- DONE:
  - `dump_done = 1`.
  - When `halted == 0`, return to IDLE; the block is re-armed for the next halt.
- `halted` falling during HDR or REGS is ignored; the dump always completes all 33 beats.
- Beat order: `cyc`, R0, R1, …, R31. Exactly one beat has `dump_last = 1`.
- The block does not block register-file writes. The core must not write while halted; such writes are not defined behaviour.

## Timing
- Reset (`rst_b` low at a posedge) sets:
  - state IDLE;
  - `dump_valid`, `dump_last`, `dump_busy`, `dump_done` = 0;
  - `dump_data` = 0, `idx` = 0, `cyc` = 0, `halted_q` = 0.
- Reset asserted mid-dump aborts the dump at that edge: `dump_valid` is low in the following cycle, and no partial-dump completion occurs.
- Latency: if `halted` first samples 1 at edge N, `dump_valid` is 1 after edge N and the header equals `cyc` at edge N.
- Handshake:
  - While `dump_valid && !dump_ready`, `dump_data` and `dump_last` hold stable and `dump_valid` stays high.
  - `dump_valid` never drops without an accept, except on reset.
- Throughput: with `dump_ready` held high, 33 beats occupy 33 consecutive cycles.
- `rf_num` switches to `idx` in the cycle after the trigger edge and returns to `cpu_rs_num` in the cycle after the R31 accept.
- `dump_done` rises in the cycle after the R31 accept. It falls in the cycle after `halted` is sampled low in DONE.

## Test plan
- **Basic dump:** preload Rk = 0x1000+k (R0 reads 0), `dump_ready` = 1, raise `halted` at cycle 50.
  - Beat 0 = 50, then 0x0, 0x1001, …, 0x101F.
  - `dump_last` only on the 33rd beat; `dump_done` high afterwards.
- **Backpressure:** toggle `dump_ready` with a pseudo-random 30% duty.
  - Identical 33-beat sequence to the basic dump.
  - `dump_data` stable on every stalled cycle; no beat dropped or duplicated.
- **Re-arm:** complete a dump, drop `halted` for 3 cycles, raise it again.
  - Second header reflects the new cycle count; second 33-beat dump is identical in register content.
  - `halted` held high after DONE produces no second dump.
- **Reset mid-dump:** pull `rst_b` low after beat 10 is accepted.
  - Next cycle: `dump_valid` = 0, `dump_busy` = 0, `rf_num` = `cpu_rs_num`, `cyc` = 0.
  - A fresh halt then produces a full dump.
- **Halt glitch:** `halted` high for 1 cycle only.
  - Full dump still completes.
  - Block returns to IDLE immediately after DONE because `halted` = 0.
- **Counter wrap:** force `cyc` to 0xFFFFFFFE, trigger 3 cycles later.
  - Header = 0x00000001.
